// File: rtl/qpu_exu_wbck_arbt_pkg.sv
// Shared QPU write-back definitions: requester IDs, starvation default and selector helpers.
// Round-robin helpers are used only when QPU_WBCK_RR_EN is defined.
package qpu_exu_wbck_arbt_pkg;

  localparam int QPU_WBCK_REQ_NUM    = 3;
  localparam int QPU_WBCK_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    WBCK_ALU = 2'd0,
    WBCK_LSU = 2'd1,
    WBCK_FMR = 2'd2
  } wbck_id_e;

  localparam int ID_ALU = int'(WBCK_ALU);
  localparam int ID_LSU = int'(WBCK_LSU);
  localparam int ID_FMR = int'(WBCK_FMR);

  // Fixed order lsu > fmr > alu, one-hot result.
  function automatic logic [2:0] prio_pick(input logic [2:0] r);
    prio_pick = '0;
    if (r[ID_LSU])      prio_pick[ID_LSU] = 1'b1;
    else if (r[ID_FMR]) prio_pick[ID_FMR] = 1'b1;
    else if (r[ID_ALU]) prio_pick[ID_ALU] = 1'b1;
  endfunction

  function automatic wbck_id_e nxt_id(input wbck_id_e id);
    case (id)
      WBCK_ALU: nxt_id = WBCK_LSU;
      WBCK_LSU: nxt_id = WBCK_FMR;
      default:  nxt_id = WBCK_ALU;
    endcase
  endfunction

  function automatic wbck_id_e gnt_id(input logic [2:0] g);
    gnt_id = g[ID_FMR] ? WBCK_FMR : (g[ID_LSU] ? WBCK_LSU : WBCK_ALU);
  endfunction

  // First requester at or after the pointer, wrapping alu -> lsu -> fmr.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input wbck_id_e p);
    wbck_id_e id;
    id      = p;
    rr_pick = '0;
    for (int k = 0; k < 3; k++) begin
      if (rr_pick == 3'b000 && r[id]) rr_pick[id] = 1'b1;
      id = nxt_id(id);
    end
  endfunction

endpackage

// File: rtl/qpu_exu_wbck_arbt_if.sv
// Write-back bus between the three execution requesters and the arbiter.
interface qpu_exu_wbck_arbt_if #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 6
);
  logic               alu_wbck_valid;
  logic               alu_wbck_ready;
  logic [RFIDX_W-1:0] alu_wbck_idx;
  logic [XLEN-1:0]    alu_wbck_data;

  logic               lsu_wbck_valid;
  logic               lsu_wbck_ready;
  logic [RFIDX_W-1:0] lsu_wbck_idx;
  logic [XLEN-1:0]    lsu_wbck_data;

  logic               fmr_wbck_valid;
  logic               fmr_wbck_ready;
  logic [RFIDX_W-1:0] fmr_wbck_idx;
  logic [XLEN-1:0]    fmr_wbck_data;

  logic               cwbck_dest_wen;
  logic [RFIDX_W-1:0] cwbck_dest_idx;
  logic [XLEN-1:0]    cwbck_dest_data;
  logic               qcwbck_dest_wen;
  logic [RFIDX_W-1:0] qcwbck_dest_idx;
  logic [XLEN-1:0]    qcwbck_dest_data;
  logic               wbck_drop;
  logic               wbck_idle;

  modport master (
    output alu_wbck_valid, alu_wbck_idx, alu_wbck_data,
    output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_data,
    output fmr_wbck_valid, fmr_wbck_idx, fmr_wbck_data,
    input  alu_wbck_ready, lsu_wbck_ready, fmr_wbck_ready,
    input  cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data,
    input  qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data,
    input  wbck_drop, wbck_idle
  );

  modport slave (
    input  alu_wbck_valid, alu_wbck_idx, alu_wbck_data,
    input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_data,
    input  fmr_wbck_valid, fmr_wbck_idx, fmr_wbck_data,
    output alu_wbck_ready, lsu_wbck_ready, fmr_wbck_ready,
    output cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data,
    output qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data,
    output wbck_drop, wbck_idle
  );
endinterface

// File: rtl/qpu_exu_wbck_arbt_sel.sv
// 3-way grant selector for one write-back class (C or Q).
// Default: lsu > fmr > alu with loss counters; QPU_WBCK_RR_EN: round-robin pointer.
module qpu_exu_wbck_arbt_sel
  import qpu_exu_wbck_arbt_pkg::*;
#(
  parameter int STARVE_MAX = QPU_WBCK_STARVE_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt
);

`ifdef QPU_WBCK_RR_EN
  wbck_id_e ptr;

  assign gnt = rr_pick(req, ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= WBCK_ALU;
    else if (|gnt) ptr <= nxt_id(gnt_id(gnt));
  end
`else
  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STARVE_MAX);

  logic [2:0][CNT_W-1:0] cnt;
  logic [2:0]            starve;

  for (genvar i = 0; i < 3; i++) begin : g_starve
    assign starve[i] = req[i] & (cnt[i] == CNT_SAT);
  end

  // Saturated requesters preempt; among them the default order still holds.
  assign gnt = (|starve) ? prio_pick(starve) : prio_pick(req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || gnt[i])   cnt[i] <= '0;
        else if (cnt[i] != CNT_SAT) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/qpu_gnrl_dfflr.sv
// General DFF library cell: load enable, asynchronous active-high reset to zero.
module qpu_gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       qout <= '0;
    else if (lden) qout <= dnxt;
  end
endmodule

// File: rtl/qpu_exu_wbck_arbt.sv
// QPU execution write-back arbiter: alu/lsu/fmr onto classical and quantum register-file ports.
// Optional QPU_WBCK_RR_EN swaps fixed priority + starvation counters for round-robin.
module qpu_exu_wbck_arbt
  import qpu_exu_wbck_arbt_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 6,
  parameter int QCONST_NUM = 13,
  parameter int STARVE_MAX = QPU_WBCK_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  qpu_exu_wbck_arbt_if.slave bus
);
  localparam int NREQ  = QPU_WBCK_REQ_NUM;
  localparam int LOW_W = RFIDX_W - 1;

  logic [NREQ-1:0]              vld;
  logic [NREQ-1:0][RFIDX_W-1:0] idx;
  logic [NREQ-1:0][XLEN-1:0]    dat;
  logic [1:0][NREQ-1:0]         cls_req, cls_gnt;
  logic [1:0]                   wen_nxt, drop_nxt, wen_q;
  logic [1:0][RFIDX_W-1:0]      idx_q;
  logic [1:0][XLEN-1:0]         dat_q;
  logic                         drop_q;

  assign vld[ID_ALU] = bus.alu_wbck_valid;
  assign vld[ID_LSU] = bus.lsu_wbck_valid;
  assign vld[ID_FMR] = bus.fmr_wbck_valid;
  assign idx[ID_ALU] = bus.alu_wbck_idx;
  assign idx[ID_LSU] = bus.lsu_wbck_idx;
  assign idx[ID_FMR] = bus.fmr_wbck_idx;
  assign dat[ID_ALU] = bus.alu_wbck_data;
  assign dat[ID_LSU] = bus.lsu_wbck_data;
  assign dat[ID_FMR] = bus.fmr_wbck_data;

  // Class 0 = classical file (idx MSB clear), class 1 = quantum file.
  for (genvar c = 0; c < 2; c++) begin : g_cls
    logic [RFIDX_W-1:0] s_idx;
    logic [XLEN-1:0]    s_dat;
    logic               ro;

    // Requests are masked in reset so ready stays low and nothing is counted.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign cls_req[c][i] = vld[i] & ~rst & (idx[i][RFIDX_W-1] == 1'(c));
    end

    qpu_exu_wbck_arbt_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
      .clk (clk),
      .rst (rst),
      .req (cls_req[c]),
      .gnt (cls_gnt[c])
    );

    always_comb begin
      s_idx = '0;
      s_dat = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (cls_gnt[c][i]) begin
          s_idx |= idx[i];
          s_dat |= dat[i];
        end
      end
    end

    // Read-only targets: x0 in the classical file, the constant qubit slots in the quantum file.
    if (c == 0) begin : g_c_ro
      assign ro = (s_idx[LOW_W-1:0] == '0);
    end else begin : g_q_ro
      assign ro = (int'(s_idx[LOW_W-1:0]) < QCONST_NUM);
    end

    assign wen_nxt[c]  = (|cls_gnt[c]) & ~ro;
    assign drop_nxt[c] = (|cls_gnt[c]) &  ro;

    qpu_gnrl_dfflr #(.DW(1)) u_wen (
      .clk (clk), .rst (rst), .lden (1'b1), .dnxt (wen_nxt[c]), .qout (wen_q[c])
    );
    // idx/data only load on a real write so they hold across idle and dropped cycles.
    qpu_gnrl_dfflr #(.DW(RFIDX_W)) u_idx (
      .clk (clk), .rst (rst), .lden (wen_nxt[c]), .dnxt (s_idx), .qout (idx_q[c])
    );
    qpu_gnrl_dfflr #(.DW(XLEN)) u_dat (
      .clk (clk), .rst (rst), .lden (wen_nxt[c]), .dnxt (s_dat), .qout (dat_q[c])
    );
  end

  qpu_gnrl_dfflr #(.DW(1)) u_drop (
    .clk (clk), .rst (rst), .lden (1'b1), .dnxt (|drop_nxt), .qout (drop_q)
  );

  assign bus.alu_wbck_ready = cls_gnt[0][ID_ALU] | cls_gnt[1][ID_ALU];
  assign bus.lsu_wbck_ready = cls_gnt[0][ID_LSU] | cls_gnt[1][ID_LSU];
  assign bus.fmr_wbck_ready = cls_gnt[0][ID_FMR] | cls_gnt[1][ID_FMR];

  assign bus.cwbck_dest_wen   = wen_q[0];
  assign bus.cwbck_dest_idx   = idx_q[0];
  assign bus.cwbck_dest_data  = dat_q[0];
  assign bus.qcwbck_dest_wen  = wen_q[1];
  assign bus.qcwbck_dest_idx  = idx_q[1];
  assign bus.qcwbck_dest_data = dat_q[1];
  assign bus.wbck_drop        = drop_q;
  assign bus.wbck_idle        = rst | ~((|vld) | (|wen_q));

endmodule

// File: tb/tb_qpu_exu_wbck_arbt.sv
// Self-checking bench for qpu_exu_wbck_arbt: vector table plus hand sequences, scoreboarded outputs.
module tb_qpu_exu_wbck_arbt;
  localparam int XLEN = 32;
  localparam int RW   = 6;
  localparam int OW   = 2 * (1 + RW + XLEN) + 1;

  typedef logic [2:0][RW-1:0]   idx3_t;
  typedef logic [2:0][XLEN-1:0] dat3_t;

  typedef struct packed {
    logic            cwen;
    logic [RW-1:0]   cidx;
    logic [XLEN-1:0] cdat;
    logic            qwen;
    logic [RW-1:0]   qidx;
    logic [XLEN-1:0] qdat;
    logic            drop;
  } out_t;

  typedef struct {
    logic [2:0] vld;
    idx3_t      idx;
    dat3_t      dat;
    logic [2:0] rdy;
    logic       cwen;
    logic       qwen;
    logic       drop;
    bit         prio;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  out_t sb[$];
  out_t last;
  vec_t vt[$];

  always #5 clk = ~clk;

  qpu_exu_wbck_arbt_if #(.XLEN(XLEN), .RFIDX_W(RW)) bus ();

  qpu_exu_wbck_arbt #(
    .XLEN(XLEN), .RFIDX_W(RW), .QCONST_NUM(13), .STARVE_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic idx3_t mk_idx(input logic [RW-1:0] a, input logic [RW-1:0] l, input logic [RW-1:0] f);
    return {f, l, a};
  endfunction

  function automatic dat3_t mk_dat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] l, input logic [XLEN-1:0] f);
    return {f, l, a};
  endfunction

  function automatic vec_t mkv(input logic [2:0] v, input idx3_t ix, input dat3_t dt, input logic [2:0] r,
                               input logic cw, input logic qw, input logic dr, input bit p);
    vec_t x;
    x.vld = v; x.idx = ix; x.dat = dt; x.rdy = r;
    x.cwen = cw; x.qwen = qw; x.drop = dr; x.prio = p;
    return x;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.cwen = bus.cwbck_dest_wen;  o.cidx = bus.cwbck_dest_idx;  o.cdat = bus.cwbck_dest_data;
    o.qwen = bus.qcwbck_dest_wen; o.qidx = bus.qcwbck_dest_idx; o.qdat = bus.qcwbck_dest_data;
    o.drop = bus.wbck_drop;
    return o;
  endfunction

  function automatic logic [2:0] rdy_now();
    return {bus.fmr_wbck_ready, bus.lsu_wbck_ready, bus.alu_wbck_ready};
  endfunction

  task automatic apply(input logic [2:0] v, input idx3_t ix, input dat3_t dt);
    bus.alu_wbck_valid = v[0]; bus.alu_wbck_idx = ix[0]; bus.alu_wbck_data = dt[0];
    bus.lsu_wbck_valid = v[1]; bus.lsu_wbck_idx = ix[1]; bus.lsu_wbck_data = dt[1];
    bus.fmr_wbck_valid = v[2]; bus.fmr_wbck_idx = ix[2]; bus.fmr_wbck_data = dt[2];
  endtask

  // One cycle: check last cycle's registered outputs, drive, check ready/idle, push expectation.
  task automatic step(input logic [2:0] v, input idx3_t ix, input dat3_t dt, input logic [2:0] r,
                      input logic cw, input logic qw, input logic dr);
    out_t e;
    logic busy;
    @(negedge clk);
    busy = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wbck_out", sample(), e);
      busy = e.cwen | e.qwen;
    end
    apply(v, ix, dt);
    #1;
    chk("ready", OW'(rdy_now()), OW'(r));
    chk("idle", OW'(bus.wbck_idle), OW'(v == 3'b000 && !busy));
    e = last;
    e.cwen = cw; e.qwen = qw; e.drop = dr;
    for (int i = 0; i < 3; i++) begin
      if (r[i] && !ix[i][RW-1] && cw) begin e.cidx = ix[i]; e.cdat = dt[i]; end
      if (r[i] &&  ix[i][RW-1] && qw) begin e.qidx = ix[i]; e.qdat = dt[i]; end
    end
    last = e;
    sb.push_back(e);
  endtask

  task automatic idle_cyc();
    step(3'b000, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    out_t e;
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wbck_out", sample(), e);
    end
  endtask

  // Valids are held high during reset to show ready stays gated.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(3'b111, mk_idx(6'h05, 6'h26, 6'h07), mk_dat(32'h1, 32'h2, 32'h3));
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_out", sample(), '0);
      chk("rst_ready", OW'(rdy_now()), '0);
      chk("rst_idle", OW'(bus.wbck_idle), OW'(1'b1));
      @(negedge clk);
    end
    apply(3'b000, '0, '0);
    sb.delete();
    last = '0;
    rst  = 1'b0;
  endtask

  initial begin
    out_t e;
    apply(3'b000, '0, '0);
    last = '0;

    vt.push_back(mkv(3'b001, mk_idx(6'h05, '0, '0), mk_dat(32'hA5A5, '0, '0), 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
    vt.push_back(mkv(3'b110, mk_idx('0, 6'h03, 6'h2D), mk_dat('0, 32'h1111, 32'h2222), 3'b110, 1'b1, 1'b1, 1'b0, 1'b0));
    vt.push_back(mkv(3'b001, mk_idx(6'h00, '0, '0), mk_dat(32'hDEAD, '0, '0), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mkv(3'b001, mk_idx(6'h25, '0, '0), mk_dat(32'hBEEF, '0, '0), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mkv(3'b111, mk_idx(6'h07, 6'h08, 6'h09), mk_dat(32'h7, 32'h8, 32'h9), 3'b010, 1'b1, 1'b0, 1'b0, 1'b1));
    vt.push_back(mkv(3'b101, mk_idx(6'h0B, '0, 6'h0A), mk_dat(32'hB, '0, 32'hA), 3'b100, 1'b1, 1'b0, 1'b0, 1'b1));
    vt.push_back(mkv(3'b001, mk_idx(6'h2C, '0, '0), mk_dat(32'hC, '0, '0), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mkv(3'b001, mk_idx(6'h2D, '0, '0), mk_dat(32'hD, '0, '0), 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
    vt.push_back(mkv(3'b011, mk_idx(6'h1F, 6'h3F, '0), mk_dat(32'h1F, 32'h3F, '0), 3'b011, 1'b1, 1'b1, 1'b0, 1'b0));
    vt.push_back(mkv(3'b110, mk_idx('0, 6'h00, 6'h20), mk_dat('0, 32'h5, 32'h6), 3'b110, 1'b0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mkv(3'b101, mk_idx(6'h01, '0, 6'h30), mk_dat(32'h11, '0, 32'h30), 3'b101, 1'b1, 1'b1, 1'b0, 1'b0));
    vt.push_back(mkv(3'b011, mk_idx(6'h21, 6'h01, '0), mk_dat(32'h21, 32'h01, '0), 3'b011, 1'b1, 1'b0, 1'b1, 1'b0));

    do_reset();

    foreach (vt[k]) begin
`ifdef QPU_WBCK_RR_EN
      if (vt[k].prio) continue;
`endif
      step(vt[k].vld, vt[k].idx, vt[k].dat, vt[k].rdy, vt[k].cwen, vt[k].qwen, vt[k].drop);
      idle_cyc();
    end

`ifndef QPU_WBCK_RR_EN
    // alu starves behind lsu for four cycles, then wins once.
    for (int k = 0; k < 6; k++)
      step(3'b011, mk_idx(6'h05, 6'h06, '0), mk_dat(32'hAAAA, 32'hBBBB, '0),
           (k == 4) ? 3'b001 : 3'b010, 1'b1, 1'b0, 1'b0);
    idle_cyc();
`else
    do_reset();
    for (int k = 0; k < 4; k++)
      step(3'b111, mk_idx(6'h01, 6'h02, 6'h03), mk_dat(32'h1, 32'h2, 32'h3),
           3'(3'b001 << (k % 3)), 1'b1, 1'b0, 1'b0);
    idle_cyc();
`endif

    // Reset lands the cycle after a grant: pending write must vanish at once.
    step(3'b001, mk_idx(6'h09, '0, '0), mk_dat(32'h99, '0, '0), 3'b001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    e = sb.pop_front();
    chk("s6_pre_rst", sample(), e);
    rst = 1'b1;
    #1;
    chk("s6_rst_out", sample(), '0);
    chk("s6_rst_ready", OW'(rdy_now()), '0);
    chk("s6_rst_idle", OW'(bus.wbck_idle), OW'(1'b1));
    apply(3'b000, '0, '0);
    @(negedge clk);
    rst  = 1'b0;
    last = '0;
    idle_cyc();
    idle_cyc();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qpu_exu_wbck_arbt.md
QPU_EXU_WBCK_ARBT -- requirements
Module: QPU_exu_wbck_arbt

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width (equals QPU_XLEN).
REQ-002 SHALL have parameter RFIDX_W, default 6, destination index width; the MSB selects the quantum file (equals QPU_RFIDX_REAL_WIDTH).
REQ-003 SHALL have parameter QCONST_NUM, default 13, the count of read-only quantum indices 0..QCONST_NUM-1 (QPU_QUBIT_NUM+1).
REQ-004 SHALL have parameter STARVE_MAX, default 4, the loss count that forces priority.
REQ-005 clk  in  1  single clock; all state is on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 {alu,lsu,fmr}_wbck_valid  in  1  per-requester write request.
REQ-008 {alu,lsu,fmr}_wbck_ready  out  1  the request is accepted this cycle.
REQ-009 {alu,lsu,fmr}_wbck_idx  in  RFIDX_W  destination index.
REQ-010 {alu,lsu,fmr}_wbck_data  in  XLEN  write data.
REQ-011 cwbck_dest_wen/idx/data  out  1/RFIDX_W/XLEN  classical-file write port.
REQ-012 qcwbck_dest_wen/idx/data  out  1/RFIDX_W/XLEN  quantum-file write port.
REQ-013 wbck_drop  out  1  one-cycle pulse when an accepted write is discarded.
REQ-014 wbck_idle  out  1  high when no requester is valid and no write-port wen is asserted.

Function
REQ-015 A request is a "C" request when idx[RFIDX_W-1]=0 and a "Q" request when idx[RFIDX_W-1]=1; each class arbitrates independently.
REQ-016 At most one C grant and one Q grant are issued per cycle; a C grant and a Q grant to different requesters in the same cycle are both legal.
REQ-017 ready is combinational, equals the grant, and is asserted only while valid is high.
REQ-018 A requester holds valid, idx and data stable until it sees ready; the block does not check this.
REQ-019 Output latency is 1 cycle: a grant in cycle N drives the selected port's wen, idx and data as registered values in cycle N+1.
REQ-020 wen is low in any cycle without a grant for that class; idx and data hold their last values when wen is low.
REQ-021 A granted C write to idx[RFIDX_W-2:0]=0 is accepted, produces no cwbck_dest_wen, and pulses wbck_drop in cycle N+1.
REQ-022 A granted Q write to idx[RFIDX_W-2:0]<QCONST_NUM is accepted, produces no qcwbck_dest_wen, and pulses wbck_drop in cycle N+1.
REQ-023 Default priority within a class is lsu > fmr > alu.
REQ-024 Each requester has a saturating loss counter per class, width clog2(STARVE_MAX+1); it increments when the requester is valid in that class and not granted, and clears on grant or when valid is low.
REQ-025 A requester whose counter equals STARVE_MAX takes top priority in its class.
REQ-026 If two counters are saturated, the default order REQ-023 resolves between them.
REQ-027 Simultaneous C and Q requests from the same requester cannot occur, since each requester carries one index.

Reset
REQ-028 While rst is high, all wen outputs, wbck_drop, all loss counters and the round-robin pointers are 0.
REQ-029 While rst is high, the idx and data outputs are 0, all ready outputs are 0, and wbck_idle is 1.
REQ-030 Reset asserted mid-operation discards any registered write; no wen is asserted in the cycle after rst deasserts unless a new grant occurs.

Configuration
REQ-031 With macro QPU_WBCK_RR_EN defined, each class uses a 3-way round-robin pointer instead of REQ-023 to REQ-026.
REQ-032 With QPU_WBCK_RR_EN defined, the pointer advances to the requester after the granted one, and loss counters are not instantiated.
REQ-033 Without QPU_WBCK_RR_EN, fixed priority with starvation counters applies.

Structure
REQ-034 The requester-ID encoding (ALU=0, LSU=1, FMR=2) and the STARVE_MAX default SHALL be placed in the shared QPU defines file.
REQ-035 Each class SHALL use one instance of the sub-module QPU_exu_wbck_arbt_sel, a 3-way selector holding the counters or pointer; this gives one instance for C and one for Q.
REQ-036 Output registers SHALL use the existing general DFF library cells.

Verification
REQ-037 Scenario 1: alu C idx=5 data=0xA5A5 in cycle N -> alu_ready in N; cwbck wen=1 idx=5 data=0xA5A5 in N+1.
REQ-038 Scenario 2: lsu C idx=3 and fmr Q idx=0x2D in the same cycle -> both ready; cwbck and qcwbck both write in N+1.
REQ-039 Scenario 3: alu and lsu hold C requests continuously with RR off -> lsu granted for 4 cycles, alu granted in the 5th cycle, then lsu again.
REQ-040 Scenario 4: alu C idx=0, then Q idx=0x25 (index 5 < 13) -> ready asserted, no wen, wbck_drop pulses once for each write.
REQ-041 Scenario 5: with QPU_WBCK_RR_EN, all three requesters hold C requests -> grants rotate alu, lsu, fmr, alu.
REQ-042 Scenario 6: rst asserted in cycle N+1 after a grant in N -> wen=0 immediately; no write occurs after rst deasserts.
